// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the arbitrated streaming multiplexer.
package arb_mux_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_mux_grant.sv
// Combinational grant generator: fixed-priority or rotating search, with a
// packet lock that pins the grant to a single channel.
module arb_grant #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock,
    input  logic [SEL_W-1:0] lock_idx,
    input  logic             rr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);

    int   c;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        if (lock) begin
            // Locked channel owns the port even while it is not presenting data.
            grant[lock_idx] = req[lock_idx];
            idx             = lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (rr ? int'(ptr) : 0) + k;
                if (c >= N) c = c - N;
                if (!found && req[c]) begin
                    found    = 1'b1;
                    grant[c] = 1'b1;
                    idx      = SEL_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 valid/ready multiplexer with packet-aware arbitration and a
// registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int RR_MODE = 1,
    parameter int SEL_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    arb_state_e       state, state_nx;
    logic [SEL_W-1:0] lock_ch, lock_ch_nx;
    logic [SEL_W-1:0] ptr, ptr_nx;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gidx;
    logic             load, xfer, sel_last;
    logic [WIDTH-1:0] sel_data;

    arb_grant #(.N(N), .SEL_W(SEL_W)) u_grant (
        .req      (in_valid),
        .ptr      (ptr),
        .lock     (state == ARB_LOCKED),
        .lock_idx (lock_ch),
        .rr       (RR_MODE == ARB_RR),
        .grant    (grant),
        .idx      (gidx)
    );

    // load stays high while the held beat drains, giving full throughput.
    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N{load & ~rst}};
    assign xfer     = |(in_ready & in_valid);
    assign sel_last = in_last[gidx];
    assign sel_data = in_data[gidx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nx;
            lock_ch <= lock_ch_nx;
            ptr     <= ptr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lock_ch_nx = lock_ch;
        ptr_nx     = ptr;
        if (xfer) begin
            if (sel_last) begin
                state_nx = ARB_IDLE;
                if (RR_MODE == ARB_RR)
                    ptr_nx = (gidx == SEL_W'(N-1)) ? '0 : gidx + 1'b1;
            end else if (state == ARB_IDLE) begin
                state_nx   = ARB_LOCKED;
                lock_ch_nx = gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a round-robin and a fixed-priority instance on
// shared stimulus, plus a beat scoreboard on the round-robin instance.
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_last;
    logic           out_ready;

    logic [N-1:0]   rdy_rr, rdy_fx;
    logic [W-1:0]   od_rr, od_fx;
    logic           ov_rr, ov_fx, ol_rr, ol_fx;
    logic [1:0]     os_rr, os_fx;

    int total = 0;
    int bad   = 0;
    logic [34:0] sb[$];

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .N(N), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_rr), .out_data(od_rr),
        .out_valid(ov_rr), .out_last(ol_rr), .out_sel(os_rr),
        .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .N(N), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy_fx), .out_data(od_fx),
        .out_valid(ov_fx), .out_last(ol_fx), .out_sel(os_fx),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    // Scoreboard: at each falling edge, pop the beat that will drain and push
    // the beat that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (ov_rr && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_dup", {29'd0, ol_rr, os_rr, od_rr}, 64'h7fffffffff);
                end else begin
                    chk("sb_beat", {29'd0, ol_rr, os_rr, od_rr}, {29'd0, sb.pop_front()});
                end
            end
            for (int i = 0; i < N; i++)
                if (in_valid[i] && rdy_rr[i])
                    sb.push_back({in_last[i], 2'(i), in_data[i*W +: W]});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 4'hF;
        in_last = 4'hF;
        in_data = '0;
        for (int i = 0; i < N; i++) set_data(i, 32'hA0 + i);

        // reset held with every channel valid
        repeat (3) begin
            step();
            chk("rst_rdy", rdy_rr, 0);
            chk("rst_rdy_fx", rdy_fx, 0);
            chk("rst_ov", ov_rr, 0);
            chk("rst_od", od_rr, 0);
        end
        rst = 1'b0;
        settle();
        chk("rel_rdy", rdy_rr, 4'b0001);
        step();
        chk("rel_sel", os_rr, 0);
        chk("rel_ov", ov_rr, 1);
        chk("rel_od", od_rr, 32'hA0);

        // round robin across all four channels, one beat per cycle
        for (int k = 1; k <= 4; k++) begin
            chk("rr_rdy", rdy_rr, 4'b0001 << (k % 4));
            step();
            chk("rr_sel", os_rr, k % 4);
            chk("rr_od", od_rr, 32'hA0 + (k % 4));
            chk("rr_ov", ov_rr, 1);
        end

        // fixed priority: channel 3 starved behind channel 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'b1010;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("fx_rdy", rdy_fx, 4'b0010);
            step();
            chk("fx_sel", os_fx, 1);
            chk("fx_od", od_fx, 32'hA1);
        end

        // packet lock: move ptr to 2, then a 3-beat packet on channel 2
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'b0010;
        in_last = 4'hF;
        settle();
        chk("lk_pre_rdy", rdy_rr, 4'b0010);
        step();
        in_valid = 4'b0101;
        in_last = 4'b0000;
        settle();
        chk("lk_b1_rdy", rdy_rr, 4'b0100);
        step();
        chk("lk_b1_sel", os_rr, 2);
        chk("lk_b1_last", ol_rr, 0);
        chk("lk_b2_rdy", rdy_rr, 4'b0100);
        step();
        chk("lk_b2_sel", os_rr, 2);
        chk("lk_b2_last", ol_rr, 0);
        // producer stalls; its stale in_last must not end the packet
        in_valid = 4'b0001;
        in_last = 4'b0100;
        settle();
        chk("lk_stall_rdy", rdy_rr, 4'b0000);
        step();
        chk("lk_stall_ov", ov_rr, 0);
        in_valid = 4'b0101;
        settle();
        chk("lk_b3_rdy", rdy_rr, 4'b0100);
        step();
        chk("lk_b3_sel", os_rr, 2);
        chk("lk_b3_last", ol_rr, 1);
        in_valid = 4'b1001;
        in_last = 4'hF;
        settle();
        chk("lk_next_rdy", rdy_rr, 4'b1000);
        step();
        chk("lk_next_sel", os_rr, 3);
        in_valid = 4'b0001;
        settle();
        chk("lk_wrap_rdy", rdy_rr, 4'b0001);
        step();
        chk("lk_wrap_sel", os_rr, 0);

        // backpressure: hold 0x1234 while the next beat waits
        set_data(0, 32'h1234);
        settle();
        step();
        chk("bp_od0", od_rr, 32'h1234);
        out_ready = 1'b0;
        set_data(0, 32'h5678);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("bp_rdy", rdy_rr, 0);
            chk("bp_od", od_rr, 32'h1234);
            chk("bp_ov", ov_rr, 1);
            step();
        end
        out_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", rdy_rr, 4'b0001);
        step();
        chk("bp_rel_od", od_rr, 32'h5678);
        in_valid = 4'b0000;
        step();
        chk("bp_drain_ov", ov_rr, 0);

        // reset in the middle of a packet on channel 1 (ptr is 1 here)
        set_data(0, 32'hA0);
        in_valid = 4'b0010;
        in_last = 4'b0000;
        settle();
        chk("mr_b1_rdy", rdy_rr, 4'b0010);
        step();
        chk("mr_b1_sel", os_rr, 1);
        rst = 1'b1;
        in_valid = 4'b0011;
        settle();
        chk("mr_rst_rdy", rdy_rr, 0);
        step();
        chk("mr_rst_ov", ov_rr, 0);
        rst = 1'b0;
        settle();
        chk("mr_rel_rdy", rdy_rr, 4'b0001);
        step();
        chk("mr_rel_sel", os_rr, 0);
        chk("mr_rel_od", od_rr, 32'hA0);
        in_valid = 4'b0001;
        in_last = 4'b0001;
        step();
        in_valid = 4'b0000;
        step();
        step();
        chk("end_ov", ov_rr, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
